// File: rtl/data_mem_responder.sv
// data_mem_responder: load/store responder with lane alignment, sign/zero extension, access checking and fixed wait states.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        mem_read,
    input  logic [3:0]        mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic              load_unsigned,
    output logic [31:0]       rdata,
    output logic              stall,
    output logic              access_fault
);
    localparam int AW = $clog2(DEPTH_WORDS);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d, rmask_q, rmask_d, wmask_q, wmask_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [1:0] off_q, off_d;
    logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic uns_q, uns_d, fault_q, fault_d;
    logic [31:0] mem [DEPTH_WORDS];
    logic req, enter_resp, is_rd, is_wr, legal, we, uns;
    logic [3:0] rm, wm, mask, be;
    logic [AW-1:0] ix;
    logic [1:0] off;
    logic [31:0] wd, wlanes, word, shifted, ld;
    if (ADDR_W > AW + 2) begin : g_unused
        logic unused_addr;
        assign unused_addr = ^addr[ADDR_W-1:AW+2];
    end
    assign req = |mem_read || |mem_write;
    assign stall = req && state_q != RESP;
    assign rdata = rdata_q;
    assign access_fault = fault_q;
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        rmask_d = rmask_q;
        wmask_d = wmask_q;
        idx_d = idx_q;
        off_d = off_q;
        wdata_d = wdata_q;
        uns_d = uns_q;
        if (state_q == IDLE && req) begin
            rmask_d = mem_read;
            wmask_d = mem_write;
            idx_d = addr[AW+1:2];
            off_d = addr[1:0];
            wdata_d = wdata;
            uns_d = load_unsigned;
            cnt_d = 4'(WAIT_CYCLES);
            state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end else if (state_q == WAIT) begin
            cnt_d = cnt_q - 4'd1;
            state_d = (cnt_q <= 4'd1) ? RESP : WAIT;
        end else if (state_q == RESP) begin
            state_d = IDLE;
        end
        // with zero wait states the access commits before the latch registers fill
        rm = (state_q == IDLE) ? mem_read : rmask_q;
        wm = (state_q == IDLE) ? mem_write : wmask_q;
        ix = (state_q == IDLE) ? addr[AW+1:2] : idx_q;
        off = (state_q == IDLE) ? addr[1:0] : off_q;
        wd = (state_q == IDLE) ? wdata : wdata_q;
        uns = (state_q == IDLE) ? load_unsigned : uns_q;
        enter_resp = state_d == RESP && state_q != RESP;
        is_rd = |rm;
        is_wr = |wm;
        mask = is_rd ? rm : wm;
        legal = !(is_rd && is_wr) &&
                (mask == 4'b0001 || (mask == 4'b0011 && !off[0]) || (mask == 4'b1111 && off == 2'd0));
        be = mask << off;
        wlanes = (mask == 4'b0001) ? {4{wd[7:0]}} : (mask == 4'b0011) ? {2{wd[15:0]}} : wd;
        word = mem[ix];
        shifted = word >> {off, 3'b000};
        ld = (mask == 4'b0001) ? {{24{!uns && shifted[7]}}, shifted[7:0]} :
             (mask == 4'b0011) ? {{16{!uns && shifted[15]}}, shifted[15:0]} : shifted;
        we = enter_resp && legal && is_wr;
        rdata_d = enter_resp ? ((legal && is_rd) ? ld : 32'd0) : rdata_q;
        fault_d = enter_resp && !legal;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q <= 4'd0;
            rmask_q <= 4'd0;
            wmask_q <= 4'd0;
            idx_q <= '0;
            off_q <= 2'd0;
            wdata_q <= 32'd0;
            uns_q <= 1'b0;
            rdata_q <= 32'd0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            rmask_q <= rmask_d;
            wmask_q <= wmask_d;
            idx_q <= idx_d;
            off_q <= off_d;
            wdata_q <= wdata_d;
            uns_q <= uns_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end
    // RAM is never reset; a store racing a reset assertion must not commit
    always_ff @(posedge clk) begin
        if (we && rst_n)
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[ix][8*b +: 8] <= wlanes[8*b +: 8];
    end
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Data-memory responder at the far end of the core's load/store interface. Consumes the byte-mask read/write strobes the decode stage issues (4'b0001 byte, 4'b0011 half, 4'b1111 word) together with the ALU effective address. Performs lane alignment, sign/zero extension and access checking against an internal word-organised RAM. Holds the pipeline with `stall` for a fixed, parameterised latency.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the RAM; must be a power of two, at least 2.
ADDR_W, 32, width of the byte address input.
WAIT_CYCLES, 2, extra wait states per access, 0..15.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
mem_read  input  4  load byte mask from decode; 0 means no load
mem_write  input  4  store byte mask from decode; 0 means no store
addr  input  ADDR_W  byte effective address
wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
load_unsigned  input  1  1 selects zero extension (LBU/LHU); 0 selects sign extension
rdata  output  32  aligned, extended load result; valid in RESP
stall  output  1  pipeline hold request
access_fault  output  1  one-cycle pulse in RESP for an illegal or misaligned access

Behaviour:
- Request present: mem_read != 0 or mem_write != 0. Upstream holds addr, masks, wdata and load_unsigned stable while stall = 1.
- FSM states: IDLE, WAIT, RESP.
  - IDLE with a request: latch the request, load the wait counter with WAIT_CYCLES, go to WAIT. If WAIT_CYCLES = 0, go directly to RESP.
  - WAIT: decrement the counter each cycle; go to RESP on the cycle the counter reaches 0.
  - RESP: lasts one cycle, then IDLE unconditionally. A request seen in the following IDLE cycle is a new request.
  - IDLE with no request: stay in IDLE.
- stall is combinational: stall = request present AND state != RESP. Each access therefore stalls WAIT_CYCLES+1 cycles and completes in the RESP cycle.
- Word index = addr[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4. off = addr[1:0].
- Legality check, evaluated on the latched request:
  - Mask must be one of 0001, 0011, 1111.
  - mem_read and mem_write must not both be nonzero.
  - Half access needs off[0] = 0; word access needs off = 0.
  - Any violation: no RAM access, rdata = 0, access_fault = 1 during RESP.
- Store: byte enables = mask << off; RAM lanes receive wdata replicated per size (byte ×4, half ×2). Written on the clock edge that enters RESP. Unselected lanes are untouched.
- Load: RAM word read on the edge entering RESP. Selected lanes are shifted down by off*8. Sign-extended from bit 7 or 15 unless load_unsigned = 1. Word loads are passed unchanged. rdata is registered and held until the next RESP.
- Reset (async, rst_n low):
  - state = IDLE, counter = 0, rdata = 0, access_fault = 0. stall follows its equation (0 in IDLE with no request).
  - RAM contents are not reset.
  - Reset asserted during WAIT aborts the access; no store is committed.
- RESP with no request still present (upstream withdrew): the access still completes and the store still commits; stall = 0.

Test Plan:
1. WAIT_CYCLES=2: store word 0xDEADBEEF @0x10 -> stall high exactly 3 cycles; then word load @0x10 -> rdata = 0xDEADBEEF in RESP, access_fault = 0.
2. Store byte 0x80 @0x13 (mask 0001) over 0x00000000 -> word @0x10 reads 0x80000000. LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080.
3. Store half 0x1234 @0x16, then LH @0x16 -> 0x00001234. LH @0x15 -> access_fault pulse, rdata = 0, word @0x14 unchanged.
4. WAIT_CYCLES=0: back-to-back word store @0x20 = 0xA5A5A5A5, then word load @0x20 -> each stalls 1 cycle; load returns 0xA5A5A5A5.
5. rst_n pulsed low mid-WAIT of a store 0x11111111 @0x30 (prior value 0x0) -> state IDLE, rdata = 0; later load @0x30 returns 0x0.
6. mem_read=0011 and mem_write=1111 together, or mask 0111 -> access_fault = 1 in RESP, no RAM change. Address @0x10 + DEPTH_WORDS*4 aliases to @0x10.
